mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Round-robin controller that shares the single instruction-memory port (req/ready/valid, 128-bit packet, variable latency) between NUM_REQ requesters, e.g. fetch and prefetch.
- Owns the memory handshake: latches the winning address, holds the request, and captures the returned packet.
- Returns a one-cycle response to the granted requester, flagged with memory valid and timeout status.
- Sits between the front-end fetch logic and the memory model / memory controller.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 128, memory packet width.
- TIMEOUT, 64, WAIT cycles before a request is aborted; must exceed the worst-case memory latency (≥18).

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held with address stable until its resp_valid cycle inclusive.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- resp_valid  out  NUM_REQ  one-hot, one-cycle response pulse.
- resp_data  out  DATA_WIDTH  captured packet, valid with resp_valid.
- resp_ok  out  1  memory valid flag for the response.
- resp_timeout  out  1  set when the response is an abort.
- busy  out  1  high in every state except IDLE.
- mem_req  out  1  request to memory.
- mem_addr  out  ADDR_WIDTH  latched address of the granted request.
- mem_ready  in  1  memory completion pulse.
- mem_data  in  DATA_WIDTH  memory packet, valid with mem_ready.
- mem_valid  in  1  address-in-range flag, sampled with mem_ready.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset values: state=IDLE; all outputs 0; rr pointer selects requester 0 as highest priority; timeout counter 0.
- Reset mid-operation aborts the transaction with no response pulse. Any later stray mem_ready is ignored because it only counts in WAIT.
- IDLE:
  - If any req_valid is set, grant by round-robin: highest priority is (last_grant+1) mod NUM_REQ.
  - Latch the grant index and its address into mem_addr, then go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE (1 cycle): mem_req=1, then go to WAIT. The timeout counter is cleared.
- WAIT:
  - mem_req = !mem_ready (combinational), so the request is never re-latched on the completion cycle.
  - On mem_ready=1: capture mem_data into resp_data and mem_valid into resp_ok; resp_timeout=0; go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT-1 without mem_ready: resp_data=0, resp_ok=0, resp_timeout=1; go to RESP.
- RESP (1 cycle): resp_valid[grant]=1, mem_req=0. Update last_grant=grant, then go to IDLE.
- mem_ready is ignored in IDLE, ISSUE and RESP.
- req_valid sampled in the IDLE cycle after RESP is treated as a new request.
- Minimum latency: 3 cycles from the IDLE grant to RESP when mem_ready arrives in the first WAIT cycle. Back-to-back throughput is one transaction per (latency+1) cycles.
- A requester dropping req_valid before its response is a protocol violation. The transaction still completes and the pulse is still issued.
- Only one transaction is outstanding at a time; there is no buffering.
- The timeout counter width is $clog2(TIMEOUT)+1 and saturates; it never wraps.
- rr pointer update:
  - last_grant changes only in RESP, so the pointer advances on timeout responses too.
  - Wrap-around: grant at index NUM_REQ-1 makes index 0 highest priority next.

Decomposition:
- Package mem_arb_pkg holds the state enum (IDLE, ISSUE, WAIT, RESP as 2-bit typedef) and the default width constants, matching the existing instruction-packet width defines.
- Sub-module rr_arbiter (NUM_REQ parameter) holds the combinational round-robin pick.
  - Inputs: request vector and last_grant.
  - Outputs: one-hot grant and its index.
  - Reusable by a future data-port arbiter.

Test Plan:
- Single request, fixed memory latency: req_valid[0]=1, addr=5, mem_ready 4 cycles after mem_req rises -> resp_valid[0] pulses once with resp_data=mem packet 5, resp_ok=1; mem_req high exactly from ISSUE until the mem_ready cycle.
- Simultaneous requests after reset: req_valid=2'b11, addr0=1, addr1=2 -> requester 0 served first, then requester 1. With both held continuously, grants alternate 0,1,0,1 over 4 transactions.
- Out-of-range address: addr=100 against the 40-entry model -> resp_valid pulse with resp_ok=0, resp_timeout=0.
- Timeout: memory stub never asserts mem_ready, TIMEOUT=64 -> resp_valid after 64 WAIT cycles with resp_timeout=1, resp_data=0. The next request is granted normally and the rr pointer has advanced.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT, then stub asserts mem_ready -> no resp_valid, state IDLE, mem_req=0, busy=0. A fresh request then completes normally.
- Randomized latency 1–16 with random requests over 1000 transactions -> every request gets exactly one response, in grant order, with data matching a scoreboard.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and default widths for the instruction-memory request arbiter.
// The width constants match the existing instruction-packet width defines.
package mem_arb_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 32;
    localparam int unsigned MEM_DATA_WIDTH = 128;
    localparam int unsigned DEF_NUM_REQ    = 2;
    localparam int unsigned DEF_TIMEOUT    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Width of a requester index; at least one bit even for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the requester after last_grant has the
// highest priority, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IDX_W  = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    int unsigned          cand;
    logic                 found;
    logic [NUM_REQ-1:0]   shifted;

    // Scan offsets 1..NUM_REQ from last_grant; the first requesting index wins.
    always_comb begin
        cand      = 0;
        found     = 1'b0;
        shifted   = '0;
        grant_idx = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = 32'(last_grant) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            shifted = req >> cand;
            if (!found && shifted[0]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
        grant = '0;
        if (found) begin
            grant = NUM_REQ'(1) << grant_idx;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin controller sharing the single instruction-memory port between
// NUM_REQ requesters. One transaction is outstanding at a time: the winner's
// address is latched, the memory request held until completion or timeout,
// and a one-cycle response is returned to the granted requester.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic                          resp_ok,
    output logic                          resp_timeout,
    output logic                          busy,
    output logic                          mem_req,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic                          mem_ready,
    input  logic [DATA_WIDTH-1:0]         mem_data,
    input  logic                          mem_valid
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    arb_state_t          state;
    arb_state_t          state_next;
    logic [IDX_W-1:0]    last_grant;
    logic [IDX_W-1:0]    grant_q;
    logic [CNT_W-1:0]    wait_cnt;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic                wait_expired;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .grant_idx  (pick_idx)
    );

    assign pick_any     = |pick_grant;
    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Address mux for the requester the arbiter currently picks.
    always_comb begin
        pick_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; completion takes priority over expiry in the last WAIT cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_any) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (mem_ready || wait_expired) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs; mem_req drops combinationally on the completion cycle.
    always_comb begin
        mem_req    = 1'b0;
        resp_valid = '0;
        busy       = (state != IDLE);
        case (state)
            ISSUE:   mem_req = 1'b1;
            WAIT:    mem_req = !mem_ready;
            RESP:    resp_valid = NUM_REQ'(1) << grant_q;
            default: ;
        endcase
    end

    // Grant/address latch, wait counter, response capture and rr pointer update.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_q      <= '0;
            last_grant   <= IDX_W'(NUM_REQ - 1);
            mem_addr     <= '0;
            wait_cnt     <= '0;
            resp_data    <= '0;
            resp_ok      <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_q  <= pick_idx;
                        mem_addr <= pick_addr;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (mem_ready) begin
                        resp_data    <= mem_data;
                        resp_ok      <= mem_valid;
                        resp_timeout <= 1'b0;
                    end else if (wait_expired) begin
                        resp_data    <= '0;
                        resp_ok      <= 1'b0;
                        resp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    last_grant <= grant_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: the driver pushes expected responses
// computed from a requester-level round-robin model; a monitor pops them on
// every response pulse. A behavioural memory stub answers mem_req.
module tb_mem_req_arbiter;

    localparam int unsigned NREQ      = 2;
    localparam int unsigned AW        = 32;
    localparam int unsigned DW        = 128;
    localparam int unsigned TMO       = 64;
    localparam int unsigned MEM_WORDS = 40;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ-1:0]      resp_valid;
    logic [DW-1:0]        resp_data;
    logic                 resp_ok;
    logic                 resp_timeout;
    logic                 busy;
    logic                 mem_req;
    logic [AW-1:0]        mem_addr;
    logic                 mem_ready;
    logic [DW-1:0]        mem_data;
    logic                 mem_valid;

    always #5 clock = ~clock;

    mem_req_arbiter #(
        .NUM_REQ    (NREQ),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_ok      (resp_ok),
        .resp_timeout (resp_timeout),
        .busy         (busy),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_data     (mem_data),
        .mem_valid    (mem_valid)
    );

    typedef struct {
        int unsigned   idx;
        logic [DW-1:0] data;
        logic          ok;
        logic          tmo;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;

    // stub_mode: 0 fixed latency, 1 random latency 1..16, 2 never answers
    int          stub_mode = 0;
    int unsigned stub_lat  = 4;

    logic [AW-1:0] addr_of [NREQ];
    int unsigned   model_last = NREQ - 1;

    int unsigned     issue_cyc = 0;
    int unsigned     resp_cyc  = 0;
    int unsigned     hi_cnt    = 0;
    logic            prev_req  = 1'b0;
    logic [NREQ-1:0] last_resp = '0;

    function automatic logic [DW-1:0] mem_word(input int unsigned a);
        return {32'hC0DE_0000 | a, ~a, a * 32'h0101_0101, 32'h1234_5678 ^ a};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Memory stub: answers each new request after its latency with the model word.
    initial begin
        int unsigned lat;
        mem_ready = 1'b0;
        mem_data  = '0;
        mem_valid = 1'b0;
        forever begin
            @(negedge clock);
            if (mem_req && stub_mode != 2) begin
                lat = (stub_mode == 1) ? $urandom_range(16, 1) : stub_lat;
                repeat (lat) @(posedge clock);
                #1;
                mem_ready = 1'b1;
                if (mem_addr < MEM_WORDS) begin
                    mem_data  = mem_word(mem_addr);
                    mem_valid = 1'b1;
                end else begin
                    mem_data  = '0;
                    mem_valid = 1'b0;
                end
                @(posedge clock);
                #1;
                mem_ready = 1'b0;
                mem_data  = '0;
                mem_valid = 1'b0;
            end
        end
    end

    // Request-timing tracker: cycle of each mem_req rise and cycles it stays high.
    initial begin
        forever begin
            @(negedge clock);
            if (mem_req && !prev_req) begin
                issue_cyc = cyc;
                hi_cnt    = 0;
            end
            if (mem_req) hi_cnt++;
            prev_req = mem_req;
        end
    end

    // Monitor: every response pulse must match the head of the scoreboard.
    initial begin
        exp_t            e;
        logic [NREQ-1:0] oh;
        forever begin
            @(negedge clock);
            last_resp = resp_valid;
            if (resp_valid != '0) begin
                resp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", DW'(resp_valid), '0);
                end else begin
                    e  = exp_q.pop_front();
                    oh = NREQ'(1) << e.idx;
                    check("resp_valid", DW'(resp_valid), DW'(oh));
                    check("resp_data", resp_data, e.data);
                    check("resp_ok", DW'(resp_ok), DW'(e.ok));
                    check("resp_timeout", DW'(resp_timeout), DW'(e.tmo));
                end
            end
        end
    end

    // Requester-level model: requesters in mask are served in rotating order after model_last.
    task automatic push_expect(input logic [NREQ-1:0] mask, input int unsigned n_txn, input bit continuous);
        logic [NREQ-1:0] pend;
        logic [NREQ-1:0] sh;
        int unsigned     pick;
        int unsigned     c;
        bit              found;
        exp_t            e;
        pend = mask;
        for (int unsigned k = 0; k < n_txn; k++) begin
            found = 1'b0;
            pick  = 0;
            for (int unsigned j = 1; j <= NREQ; j++) begin
                c  = (model_last + j) % NREQ;
                sh = pend >> c;
                if (!found && sh[0]) begin
                    found = 1'b1;
                    pick  = c;
                end
            end
            e.idx = pick;
            if (stub_mode == 2) begin
                e.data = '0; e.ok = 1'b0; e.tmo = 1'b1;
            end else if (addr_of[pick] < MEM_WORDS) begin
                e.data = mem_word(addr_of[pick]); e.ok = 1'b1; e.tmo = 1'b0;
            end else begin
                e.data = '0; e.ok = 1'b0; e.tmo = 1'b0;
            end
            exp_q.push_back(e);
            model_last = pick;
            if (!continuous) pend = pend & ~(NREQ'(1) << pick);
        end
    endtask

    // Raise the requests in mask, drop each after its response, wait for the scoreboard to drain.
    task automatic run_round(input logic [NREQ-1:0] mask, input int unsigned n_txn, input bit continuous);
        int unsigned budget;
        bit          done;
        budget = n_txn * (TMO + 8) + 20;
        done   = 1'b0;
        push_expect(mask, n_txn, continuous);
        for (int i = 0; i < int'(NREQ); i++) req_addr[i*AW +: AW] = addr_of[i];
        req_valid = mask;
        for (int unsigned t = 0; t < budget && !done; t++) begin
            @(posedge clock);
            #1;
            if (!continuous) req_valid = req_valid & ~last_resp;
            if (exp_q.size() == 0) begin
                req_valid = '0;
                done      = 1'b1;
            end
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL round_budget: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
            req_valid = '0;
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NREQ-1:0] mask;
        int unsigned     total;
        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        for (int i = 0; i < int'(NREQ); i++) addr_of[i] = '0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", DW'(busy), '0);
        check("rst_mem_req", DW'(mem_req), '0);
        check("rst_resp_valid", DW'(resp_valid), '0);
        check("rst_resp_data", resp_data, '0);
        check("rst_resp_ok", DW'(resp_ok), '0);
        check("rst_resp_timeout", DW'(resp_timeout), '0);
        check("rst_mem_addr", DW'(mem_addr), '0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle_busy", DW'(busy), '0);

        // Simultaneous requests after reset: 0 first, then 1.
        stub_mode = 0; stub_lat = 4;
        addr_of[0] = 1; addr_of[1] = 2;
        run_round(2'b11, 2, 1'b0);

        // Both held continuously: 0,1,0,1.
        run_round(2'b11, 4, 1'b1);

        // Single request, latency 4.
        addr_of[0] = 5;
        run_round(2'b01, 1, 1'b0);
        check("lat4_issue_to_resp", DW'(resp_cyc - issue_cyc), DW'(5));
        check("lat4_mem_req_high", DW'(hi_cnt), DW'(4));

        // Minimum latency: ready in the first WAIT cycle.
        stub_lat = 1;
        addr_of[1] = 39;
        run_round(2'b10, 1, 1'b0);
        check("lat1_issue_to_resp", DW'(resp_cyc - issue_cyc), DW'(2));
        check("lat1_mem_req_high", DW'(hi_cnt), DW'(1));

        // Out-of-range address.
        stub_lat = 3;
        addr_of[0] = 100;
        run_round(2'b01, 1, 1'b0);

        // Timeout with a silent memory, then the pointer must have moved past 0.
        stub_mode = 2;
        addr_of[0] = 7;
        run_round(2'b01, 1, 1'b0);
        check("tmo_issue_to_resp", DW'(resp_cyc - issue_cyc), DW'(TMO + 1));
        check("tmo_mem_req_high", DW'(hi_cnt), DW'(TMO + 1));
        stub_mode = 0; stub_lat = 2;
        addr_of[0] = 8; addr_of[1] = 9;
        run_round(2'b11, 2, 1'b0);

        // Reset in the middle of WAIT: no pulse, stray mem_ready ignored.
        stub_lat = 10;
        addr_of[0] = 3;
        req_addr[0 +: AW] = addr_of[0];
        req_valid = 2'b01;
        repeat (4) @(posedge clock);
        #1;
        check("wait_busy", DW'(busy), DW'(1));
        check("wait_mem_req", DW'(mem_req), DW'(1));
        reset     = 1'b1;
        req_valid = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midrst_busy", DW'(busy), '0);
        check("midrst_mem_req", DW'(mem_req), '0);
        repeat (12) @(posedge clock);
        #1;
        check("stray_ready_busy", DW'(busy), '0);
        check("stray_ready_mem_req", DW'(mem_req), '0);
        model_last = NREQ - 1;
        stub_lat   = 2;
        addr_of[0] = 11; addr_of[1] = 12;
        run_round(2'b11, 2, 1'b0);

        // Randomized requests and latencies.
        stub_mode = 1;
        total     = 0;
        while (total < 1000) begin
            mask = NREQ'($urandom_range(3, 1));
            for (int i = 0; i < int'(NREQ); i++) addr_of[i] = AW'($urandom_range(47, 0));
            run_round(mask, $countones(mask), 1'b0);
            total += $countones(mask);
        end
        repeat (4) @(posedge clock);
        #1;
        check("final_busy", DW'(busy), '0);
        check("final_queue_empty", DW'(exp_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
